// File: rtl/lcd_pkg.sv
// lcd_pkg: register map, mode encoding and backlight state type shared by the LCD backlight block.
package lcd_pkg;
    localparam logic [1:0] ADDR_CTRL     = 2'd0;
    localparam logic [1:0] ADDR_DUTY     = 2'd1;
    localparam logic [1:0] ADDR_PRESCALE = 2'd2;
    localparam logic [1:0] ADDR_TIMEOUT  = 2'd3;
    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_ON    = 2'd1;
    localparam logic [1:0] MODE_BLINK = 2'd2;
    localparam logic [1:0] MODE_PWM   = 2'd3;
    typedef enum logic [2:0] {ST_OFF, ST_ON, ST_BLINK, ST_PWM, ST_SLEEP} st_t;
    function automatic st_t mode_to_st(input logic [1:0] mode);
        return mode == MODE_ON ? ST_ON : mode == MODE_BLINK ? ST_BLINK : mode == MODE_PWM ? ST_PWM : ST_OFF;
    endfunction
endpackage

// File: rtl/lcd_tick_gen.sv
// lcd_tick_gen: prescaler counting 0..limit, one-cycle tick at limit, restart on clear.
module lcd_tick_gen (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] limit,
    input  logic        clear,
    output logic        tick
);
    logic [15:0] pre_cnt;
    assign tick = pre_cnt == limit;
    always_ff @(posedge clk) begin
        if (!reset_n || clear || tick) pre_cnt <= '0;
        else pre_cnt <= pre_cnt + 16'd1;
    end
endmodule

// File: rtl/lcd_backlight_ctrl.sv
// lcd_backlight_ctrl: Avalon-MM backlight sequencer (OFF/ON/BLINK/PWM).
// Define LCD_BL_TIMEOUT_EN to add the inactivity timer and SLEEP state.
module lcd_backlight_ctrl
    import lcd_pkg::*;
#(
    parameter logic [15:0] PRESCALE_RST = 16'd49999,
    parameter logic [7:0]  DUTY_RST     = 8'd128
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        activity,
    output logic        out_port
);
    logic        wr;
    logic [1:0]  mode;
    logic [7:0]  duty;
    logic [15:0] prescale;
    logic [15:0] timeout_r;
    logic        tick;
    logic [7:0]  ph_cnt;
    st_t         st, st_nxt;
    logic        timeout_ev, wake, out_nxt;
    assign wr = chipselect && !write_n;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mode     <= MODE_OFF;
            duty     <= DUTY_RST;
            prescale <= PRESCALE_RST;
        end else if (wr) begin
            if (address == ADDR_CTRL) mode <= writedata[1:0];
            if (address == ADDR_DUTY) duty <= writedata[7:0];
            if (address == ADDR_PRESCALE) prescale <= writedata[15:0];
        end
    end
    lcd_tick_gen u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .limit   (prescale),
        .clear   (wr && address == ADDR_PRESCALE),
        .tick    (tick)
    );
    // Restarting the phase on a CTRL write makes every mode begin at phase 0.
    always_ff @(posedge clk) begin
        if (!reset_n || (wr && address == ADDR_CTRL)) ph_cnt <= '0;
        else if (tick) ph_cnt <= ph_cnt + 8'd1;
    end
`ifdef LCD_BL_TIMEOUT_EN
    logic [15:0] idle_cnt;
    logic        unused_bits;
    assign unused_bits = ^writedata[31:16];
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            timeout_r <= '0;
            idle_cnt  <= '0;
        end else begin
            if (wr && address == ADDR_TIMEOUT) timeout_r <= writedata[15:0];
            if (activity || wr || timeout_ev) idle_cnt <= '0;
            else if (tick && idle_cnt != 16'hFFFF) idle_cnt <= idle_cnt + 16'd1;
        end
    end
    // Widened compare so a saturated idle_cnt never matches by wrap-around.
    assign timeout_ev = (st == ST_ON || st == ST_BLINK || st == ST_PWM) && timeout_r != '0 && tick &&
                        ({1'b0, idle_cnt} + 17'd1 == {1'b0, timeout_r}) && !activity;
    assign wake = st == ST_SLEEP && (wr || activity);
`else
    logic unused_bits;
    assign unused_bits = ^{activity, writedata[31:16]};
    assign timeout_r  = '0;
    assign timeout_ev = 1'b0;
    assign wake       = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            st       <= ST_OFF;
            out_port <= 1'b0;
        end else begin
            st       <= st_nxt;
            out_port <= out_nxt;
        end
    end
    always_comb begin
        st_nxt = st;
        if (wr && address == ADDR_CTRL) st_nxt = mode_to_st(writedata[1:0]);
        else if (wake) st_nxt = mode_to_st(mode);
        else if (timeout_ev) st_nxt = ST_SLEEP;
        out_nxt = st == ST_ON || (st == ST_BLINK && ph_cnt[7]) || (st == ST_PWM && ph_cnt < duty);
    end
    always_comb begin
        readdata = address == ADDR_CTRL     ? {30'd0, mode} :
                   address == ADDR_DUTY     ? {24'd0, duty} :
                   address == ADDR_PRESCALE ? {16'd0, prescale} :
                                              {15'd0, st == ST_SLEEP, timeout_r};
    end
endmodule

// File: doc/lcd_backlight_ctrl.md
# lcd_backlight_ctrl

Avalon-MM slave that sequences the single-bit LCD backlight enable in the LCD subsystem. Software selects OFF, ON, BLINK or PWM dimming; the block generates the backlight waveform from a programmable tick prescaler and drives it to the panel. An optional inactivity timer blanks the backlight after a programmable idle time and restores it on activity.

## Interface
- PRESCALE_RST, 49999: reset value of PRESCALE; tick period = PRESCALE+1 clocks, 1 ms at 50 MHz.
- DUTY_RST, 128: reset value of DUTY, 8-bit.
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset. Sampled on the rising edge of clk.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data.
- readdata  out  32  read data, zero-extended; combinational, zero wait states.
- activity  in  1  single-cycle user-activity pulse, e.g. a keypad or touch event.
- out_port  out  1  backlight enable, registered.

## Operation
- Registers:
  - 0 CTRL: [1:0] MODE, where 0=OFF, 1=ON, 2=BLINK, 3=PWM. Reset 0.
  - 1 DUTY: [7:0]. Reset DUTY_RST.
  - 2 PRESCALE: [15:0]. Reset PRESCALE_RST.
  - 3 TIMEOUT: [15:0] idle limit in ticks. Reset 0.
- Unused writedata bits are ignored. Unused readdata bits read 0.
- Reading address 3 returns TIMEOUT in [15:0] and SLEEP in bit 16.
- Write = chipselect && !write_n. Reads have no side effects.
- Prescaler: 16-bit `pre_cnt` counts 0..PRESCALE, then wraps to 0.
  - `tick` is high for the one cycle where `pre_cnt` == PRESCALE.
  - A write to PRESCALE clears `pre_cnt`.
  - PRESCALE=0 gives a tick every cycle.
- Phase counter: 8-bit `ph_cnt` increments on every tick and wraps from 255 to 0.
  - A write to CTRL clears `ph_cnt`, so every mode starts at phase 0.
- State machine `st`: OFF, ON, BLINK, PWM, SLEEP.
  - A CTRL write loads `st` from MODE.
  - In ON, BLINK or PWM, a timeout event moves `st` to SLEEP.
  - In SLEEP, an `activity` pulse or any register write returns `st` to the mode held in CTRL.
  - OFF never enters SLEEP.
- Next output value per state:
  - OFF: 0.
  - ON: 1.
  - BLINK: `ph_cnt`[7], i.e. 50 % duty with a 256-tick period.
  - PWM: (`ph_cnt` < DUTY). DUTY=0 gives constant 0; DUTY=255 gives 255/256 duty.
  - SLEEP: 0.
- Simultaneous events:
  - A CTRL write in the same cycle as a timeout event: the write wins.
  - `activity` in the same cycle as a timeout event: the timeout is cancelled.
- Reset mid-operation returns every register, counter and state to its reset value on the next edge.

## Timing
- Registers update on the write edge N.
- `st` and the counters reflect the write at edge N.
- out_port reflects the new state at edge N+1, i.e. one cycle of output latency.
- readdata is valid in the same cycle as address, with zero read latency.
- In BLINK and PWM, out_port changes one cycle after the tick that moves `ph_cnt` across the threshold.
- Reset values:
  - out_port = 0.
  - readdata reflects the reset register values.
  - SLEEP status bit = 0.

## Configuration
- LCD_BL_TIMEOUT_EN defined:
  - 16-bit `idle_cnt` increments on each tick, saturating at 0xFFFF.
  - `idle_cnt` clears on `activity`, on any register write, and on entry to SLEEP.
  - Timeout event = (TIMEOUT != 0) && tick && (`idle_cnt` + 1 == TIMEOUT).
  - TIMEOUT=0 disables the timer.
- LCD_BL_TIMEOUT_EN undefined:
  - `idle_cnt`, the SLEEP state and the `activity` logic are removed.
  - The TIMEOUT register reads 0 and ignores writes; status bit 16 reads 0.
  - The `activity` port remains present and is unused.

## Structure
- Shared package `lcd_pkg`:
  - Register address constants (ADDR_CTRL, ADDR_DUTY, ADDR_PRESCALE, ADDR_TIMEOUT).
  - MODE encoding constants.
  - The `st` state enum typedef.
- One sub-module, `lcd_tick_gen`: the prescaler, with inputs limit and clear and output tick.
- The register file, FSM, phase counter and idle counter remain in the top level.

## Test plan
- Reset with reset_n low for 2 cycles, then read addresses 0..3 -> 0, 128, 49999, 0; out_port = 0.
- PRESCALE=0, CTRL=2 -> out_port low for 128 cycles, then high for 128, with period 256 cycles and the first rise 129 cycles after the write edge.
- PRESCALE=0, DUTY=64, CTRL=3 -> out_port high for 64 of every 256 cycles. DUTY=0 gives constant 0; DUTY=255 gives high 255 of 256 cycles.
- CTRL=1 -> out_port = 1 exactly one cycle after the write edge. CTRL=0 -> out_port = 0 one cycle after.
- With LCD_BL_TIMEOUT_EN: PRESCALE=0, TIMEOUT=10, CTRL=1, no activity.
  - out_port falls 10 ticks after the write and the status read returns bit16 = 1.
  - One `activity` pulse -> out_port = 1 two cycles later and bit16 = 0.
- `activity` coincident with the timeout tick -> no SLEEP entry. CTRL write coincident with the timeout tick -> the new mode is taken and there is no SLEEP.
